// File: rtl/sd_read_scheduler.sv
// rtl/sd_read_scheduler.sv - SD SPI-mode power-up sequencer and round-robin CMD17 read scheduler
module sd_read_scheduler #(
    parameter int INIT_DELAY     = 74,
    parameter int CS_DELAY       = 16,
    parameter int ACMD41_RETRIES = 255,
    parameter int NUM_WORDS      = 256
) (
    input  logic        clk400,
    input  logic        reset,
    input  logic        req0,
    input  logic [22:0] addr0,
    input  logic        req1,
    input  logic [22:0] addr1,
    output logic        grant0,
    output logic        grant1,
    output logic        done0,
    output logic        done1,
    output logic        rd_err,
    output logic        ready,
    output logic        fatal,
    output logic        sd_cs,
    output logic        cmd_start,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg,
    input  logic        cmd_done,
    input  logic [7:0]  cmd_response,
    input  logic        cache_we
);

    typedef enum logic [3:0] {
        S_PWR_WAIT, S_CS_GAP, S_CMD0, S_WAIT0, S_CMD55, S_WAIT55, S_ACMD41,
        S_WAIT41, S_IDLE, S_RD17, S_WAIT17, S_COMPLETE, S_FAIL
    } state_t;

    localparam int             CW        = 16;
    localparam logic [CW-1:0]  INIT_CNT  = CW'(INIT_DELAY);
    localparam logic [CW-1:0]  GAP_CNT   = CW'(CS_DELAY);
    localparam logic [CW-1:0]  RETRY_CNT = CW'(ACMD41_RETRIES);
    localparam logic [CW-1:0]  ONE       = CW'(1);
    localparam logic [8:0]     WORDS_EXP = 9'(NUM_WORDS);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [8:0]    words_q, words_d, words_inc;
    logic          last_grant_q, last_grant_d;
    logic          grant0_q, grant0_d, grant1_q, grant1_d;
    logic          done0_q, done0_d, done1_q, done1_d, rd_err_q, rd_err_d;
    logic          ready_q, ready_d, fatal_q, fatal_d, sd_cs_q, sd_cs_d;
    logic          cmd_start_q, cmd_start_d;
    logic [5:0]    cmd_index_q, cmd_index_d;
    logic [31:0]   cmd_arg_q, cmd_arg_d;
    logic          pick1, enter_fail, enter_cmd55;

    assign grant0    = grant0_q;
    assign grant1    = grant1_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign rd_err    = rd_err_q;
    assign ready     = ready_q;
    assign fatal     = fatal_q;
    assign sd_cs     = sd_cs_q;
    assign cmd_start = cmd_start_q;
    assign cmd_index = cmd_index_q;
    assign cmd_arg   = cmd_arg_q;

    // Outputs are computed for the state being entered, so they are valid for its whole cycle.
    always_comb begin
        words_inc    = (cache_we && words_q != 9'h1FF) ? words_q + 9'd1 : words_q;
        pick1        = req1 && (!req0 || !last_grant_q);
        state_d      = state_q;
        cnt_d        = cnt_q;
        words_d      = words_q;
        last_grant_d = last_grant_q;
        grant0_d     = grant0_q;
        grant1_d     = grant1_q;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        rd_err_d     = 1'b0;
        ready_d      = ready_q;
        fatal_d      = fatal_q;
        sd_cs_d      = sd_cs_q;
        cmd_start_d  = 1'b0;
        cmd_index_d  = cmd_index_q;
        cmd_arg_d    = cmd_arg_q;
        enter_fail   = 1'b0;
        enter_cmd55  = 1'b0;

        case (state_q)
            S_PWR_WAIT: begin
                if (cnt_q <= ONE) begin
                    state_d = S_CS_GAP;
                    cnt_d   = GAP_CNT;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            S_CS_GAP: begin
                if (cnt_q <= ONE) begin
                    state_d     = S_CMD0;
                    cnt_d       = RETRY_CNT;
                    sd_cs_d     = 1'b0;
                    cmd_start_d = 1'b1;
                    cmd_index_d = 6'd0;
                    cmd_arg_d   = 32'd0;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            S_CMD0:   state_d = S_WAIT0;
            S_WAIT0: begin
                if (cmd_done) begin
                    if (cmd_response == 8'h01) enter_cmd55 = 1'b1;
                    else                       enter_fail  = 1'b1;
                end
            end
            S_CMD55:  state_d = S_WAIT55;
            S_WAIT55: begin
                if (cmd_done) begin
                    state_d     = S_ACMD41;
                    cmd_start_d = 1'b1;
                    cmd_index_d = 6'd41;
                    cmd_arg_d   = 32'd0;
                end
            end
            S_ACMD41: state_d = S_WAIT41;
            S_WAIT41: begin
                if (cmd_done) begin
                    if (cmd_response == 8'h00) begin
                        state_d = S_IDLE;
                        ready_d = 1'b1;
                    end else if (cmd_response[0]) begin
                        cnt_d = cnt_q - ONE;
                        if (cnt_q > ONE) enter_cmd55 = 1'b1;
                        else             enter_fail  = 1'b1;
                    end else begin
                        enter_fail = 1'b1;
                    end
                end
            end
            S_IDLE: begin
                if (req0 || req1) begin
                    state_d      = S_RD17;
                    grant0_d     = !pick1;
                    grant1_d     = pick1;
                    last_grant_d = pick1;
                    words_d      = 9'd0;
                    cmd_start_d  = 1'b1;
                    cmd_index_d  = 6'd17;
                    cmd_arg_d    = {(pick1 ? addr1 : addr0), 9'd0};
                end
            end
            S_RD17:   state_d = S_WAIT17;
            S_WAIT17: begin
                words_d = words_inc;
                if (cmd_done) begin
                    state_d  = S_COMPLETE;
                    done0_d  = grant0_q;
                    done1_d  = grant1_q;
                    rd_err_d = (cmd_response != 8'h00) || (words_inc != WORDS_EXP);
                end
            end
            S_COMPLETE: begin
                state_d  = S_IDLE;
                grant0_d = 1'b0;
                grant1_d = 1'b0;
            end
            S_FAIL:   state_d = S_FAIL;
            default:  enter_fail = 1'b1;
        endcase

        if (enter_cmd55) begin
            state_d     = S_CMD55;
            cmd_start_d = 1'b1;
            cmd_index_d = 6'd55;
            cmd_arg_d   = 32'd0;
        end
        if (enter_fail) begin
            state_d  = S_FAIL;
            fatal_d  = 1'b1;
            sd_cs_d  = 1'b1;
            ready_d  = 1'b0;
            grant0_d = 1'b0;
            grant1_d = 1'b0;
        end
    end

    always_ff @(posedge clk400 or posedge reset) begin
        if (reset) begin
            state_q      <= S_PWR_WAIT;
            cnt_q        <= INIT_CNT;
            words_q      <= 9'd0;
            last_grant_q <= 1'b1;
            grant0_q     <= 1'b0;
            grant1_q     <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            rd_err_q     <= 1'b0;
            ready_q      <= 1'b0;
            fatal_q      <= 1'b0;
            sd_cs_q      <= 1'b1;
            cmd_start_q  <= 1'b0;
            cmd_index_q  <= 6'd0;
            cmd_arg_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            words_q      <= words_d;
            last_grant_q <= last_grant_d;
            grant0_q     <= grant0_d;
            grant1_q     <= grant1_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            rd_err_q     <= rd_err_d;
            ready_q      <= ready_d;
            fatal_q      <= fatal_d;
            sd_cs_q      <= sd_cs_d;
            cmd_start_q  <= cmd_start_d;
            cmd_index_q  <= cmd_index_d;
            cmd_arg_q    <= cmd_arg_d;
        end
    end

endmodule

// File: doc/sd_read_scheduler.md
Name: sd_read_scheduler

Overview:
- Sequences the SPI-mode SD command engine: runs card power-up (clock delay, CMD0, CMD55/ACMD41 retry loop), then services single-block reads (CMD17) on behalf of two requesters sharing one 256-word block cache.
- Arbitrates round-robin between the requesters and owns chip select.
- Counts cache write strobes to confirm full block delivery.
- Sits between the requester logic (instruction/data fetch) and the command engine that drives SDout/SDin.

Parameters:
- INIT_DELAY, 74: clk400 cycles with CS high before the first command.
- CS_DELAY, 16: clk400 cycles between the end of INIT_DELAY and CMD0.
- ACMD41_RETRIES, 255: maximum CMD55/ACMD41 attempts before a fatal error.
- NUM_WORDS, 256: 16-bit cache writes expected per block.

Ports:
- clk400 input 1: SD/system clock.
- reset input 1: reset, asynchronous, active-high.
- req0 input 1: requester 0 read request, level; held until done0.
- addr0 input 23: requester 0 block address.
- req1 input 1: requester 1 read request, level; held until done1.
- addr1 input 23: requester 1 block address.
- grant0 output 1: requester 0 owns the transfer/cache.
- grant1 output 1: requester 1 owns the transfer/cache.
- done0 output 1: one-cycle pulse, requester 0 block complete.
- done1 output 1: one-cycle pulse, requester 1 block complete.
- rd_err output 1: one-cycle pulse with done0/done1 when the read failed.
- ready output 1: card initialised, reads accepted.
- fatal output 1: initialisation failed; sticky until reset.
- sd_cs output 1: SPI chip select, active-low.
- cmd_start output 1: one-cycle start pulse to the command engine.
- cmd_index output 6: command number.
- cmd_arg output 32: command argument.
- cmd_done input 1: engine finished the current command.
- cmd_response input 8: R1 response, valid when cmd_done=1.
- cache_we input 1: engine cache write strobe (one per 16-bit word).

Behaviour:
- Reset:
  - state=PWR_WAIT; sd_cs=1; grant0/1, done0/1, rd_err, ready, fatal, cmd_start=0.
  - cmd_index=0, cmd_arg=0; counters load INIT_DELAY; last_grant=1.
- Reset mid-operation aborts any transfer: no done pulse is issued, and the full init sequence reruns.
- States and transitions:
  - PWR_WAIT: count INIT_DELAY cycles with sd_cs=1, then CS_GAP.
  - CS_GAP: count CS_DELAY cycles, then CMD0 with sd_cs driven 0.
  - CMD0: cmd_start=1, index 0, arg 0 → WAIT0.
  - WAIT0: on cmd_done, response==8'h01 → CMD55; otherwise → FAIL.
  - CMD55: cmd_start=1, index 55 → WAIT55.
  - WAIT55: on cmd_done → ACMD41 (response not checked).
  - ACMD41: cmd_start=1, index 41 → WAIT41.
  - WAIT41: on cmd_done:
    - 8'h00 → IDLE with ready=1.
    - bit0=1 → decrement the retry counter; if it is nonzero → CMD55, else → FAIL.
    - any other value → FAIL.
  - FAIL: fatal=1, sd_cs=1, ready=0. Terminal state.
  - IDLE: if req0|req1, choose a requester, latch its address, assert its grant → RD17.
  - RD17: cmd_start=1, index 17, cmd_arg={addr,9'b0}; clear the word counter → WAIT17.
  - WAIT17: count cache_we pulses (saturating at 511). On cmd_done → COMPLETE.
  - COMPLETE, one cycle:
    - pulse done of the granted requester.
    - rd_err=1 if response≠0 or word count≠NUM_WORDS.
    - drop the grant → IDLE.
- Arbitration:
  - Exactly one request pending → that requester.
  - Both pending → the requester opposite last_grant.
  - last_grant updates at grant time.
  - Grants are one-hot and never both asserted.
- Latency: a request sampled at IDLE edge k gives grant and cmd_start high during cycle k+1. COMPLETE follows the cmd_done cycle by one clock.
- Request dropped while granted: the transfer still completes and the done pulse is still issued.
- Address is sampled only at grant; later changes are ignored.
- cmd_index and cmd_arg are held stable from the command state through its wait state. cmd_start is high only in CMD0, CMD55, ACMD41 and RD17.
- sd_cs stays 0 from CMD0 onward except in FAIL.
- cmd_done arriving in a state that does not wait for it is ignored.
- cache_we outside WAIT17 is ignored.

Test Plan:
- Init pass: responses 01 (CMD0), 01, 01, 00 to ACMD41 → exactly 3 CMD55/ACMD41 pairs; ready=1. sd_cs high for 74+16 clocks after reset, then low.
- Init fail: CMD0 response 8'h05 → fatal=1, sd_cs=1, no further cmd_start. Separately, ACMD41 always 01 with ACMD41_RETRIES=4 → FAIL after 4 attempts.
- Single read: req0=1, addr0=23'h000003 → cmd_arg=32'h00000600, index 17. 256 cache_we then cmd_done with response 00 → done0 pulse, rd_err=0, grant0 falls.
- Contention: req0 and req1 both high in IDLE with last_grant=1 → grant0 first, then grant1. Both requests held → grants alternate 0,1,0,1.
- Short block: 255 cache_we then cmd_done → done1 with rd_err=1. Response 8'h04 with 256 words → rd_err=1. Either way, back to IDLE with ready=1.
- Reset mid-read: reset asserted during WAIT17 → all outputs at reset values immediately, no done pulse, PWR_WAIT restarts.
